multicycle_controller: RTL and testbench

//  Control FSM for the multicycle RV32I core: sequences the shared ALU/memory/regfile datapath over
//  3-5 cycles per instruction. Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU, beq, jal.

---
 rtl/riscv_mc_pkg.sv | 51 +++++
 rtl/mc_aludec.sv | 37 +++
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mc_pkg
// Description : Shared encodings for the multicycle RV32I control path.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10
    } statetype_t;

    localparam logic [6:0] C_OP_LW    = 7'b0000011;
    localparam logic [6:0] C_OP_SW    = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE = 7'b0010011;
    localparam logic [6:0] C_OP_JAL   = 7'b1101111;
    localparam logic [6:0] C_OP_BEQ   = 7'b1100011;

    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

    // Immediate format follows the opcode alone, independent of FSM state.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            C_OP_SW:  return 2'b01;
            C_OP_BEQ: return 2'b10;
            C_OP_JAL: return 2'b11;
            default:  return 2'b00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_aludec.sv
`default_nettype none
// ============================================================================
// Module      : mc_aludec
// Description : ALU decoder, maps ALUOp/funct3/funct7b5/op[5] to ALUControl.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_aludec
    import riscv_mc_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alucontrol
);

    always_comb begin
        o_alucontrol = C_ALU_ADD;
        case (i_aluop)
            C_ALUOP_ADD: o_alucontrol = C_ALU_ADD;
            C_ALUOP_SUB: o_alucontrol = C_ALU_SUB;
            C_ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type (op[5]=1) can encode sub; addi never does.
                    3'b000:  o_alucontrol = (i_op5 & i_funct7b5) ? C_ALU_SUB : C_ALU_ADD;
                    3'b010:  o_alucontrol = C_ALU_SLT;
                    3'b110:  o_alucontrol = C_ALU_OR;
                    3'b111:  o_alucontrol = C_ALU_AND;
                    default: o_alucontrol = C_ALU_ADD;
                endcase
            end
            default: o_alucontrol = C_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Moore control FSM for the multicycle RV32I core.
//               Optional MC_MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE wait on MemReady.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       InstrDone,
    output logic       Illegal
);

    statetype_t r_state;
    statetype_t w_next_state;
    statetype_t w_cur_state;

    logic [1:0] w_aluop;
    logic       w_pcupdate;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_memwrite;
    logic       w_done;
    logic       w_illegal;

`ifndef MC_MEM_WAIT_EN
    logic       w_unused_memready;
    assign w_unused_memready = MemReady;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // While in reset the datapath sees FETCH selects with every enable masked.
    assign w_cur_state = reset ? S_FETCH : r_state;

    always_comb begin
        w_next_state = S_FETCH;
        w_aluop      = C_ALUOP_ADD;
        w_pcupdate   = 1'b0;
        w_branch     = 1'b0;
        w_irwrite    = 1'b0;
        w_regwrite   = 1'b0;
        w_memwrite   = 1'b0;
        w_done       = 1'b0;
        w_illegal    = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        case (w_cur_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
`ifdef MC_MEM_WAIT_EN
                if (MemReady) begin
                    w_irwrite    = 1'b1;
                    w_pcupdate   = 1'b1;
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
`else
                w_irwrite    = 1'b1;
                w_pcupdate   = 1'b1;
                w_next_state = S_DECODE;
`endif
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    C_OP_LW, C_OP_SW: w_next_state = S_MEMADR;
                    C_OP_RTYPE:       w_next_state = S_EXECR;
                    C_OP_ITYPE:       w_next_state = S_EXECI;
                    C_OP_JAL:         w_next_state = S_JAL;
                    C_OP_BEQ:         w_next_state = S_BEQ;
                    default: begin
                        w_illegal    = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = 2'b10;
                ALUSrcB      = 2'b01;
                w_next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
`ifdef MC_MEM_WAIT_EN
                w_next_state = MemReady ? S_MEMWB : S_MEMREAD;
`else
                w_next_state = S_MEMWB;
`endif
            end
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                w_regwrite   = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
`ifdef MC_MEM_WAIT_EN
                w_done       = MemReady;
                w_next_state = MemReady ? S_FETCH : S_MEMWRITE;
`else
                w_done       = 1'b1;
                w_next_state = S_FETCH;
`endif
            end
            S_EXECR: begin
                ALUSrcA      = 2'b10;
                w_aluop      = C_ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA      = 2'b10;
                ALUSrcB      = 2'b01;
                w_aluop      = C_ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                w_pcupdate   = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite   = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA      = 2'b10;
                w_aluop      = C_ALUOP_SUB;
                w_branch     = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    mc_aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct3     (funct3),
        .i_funct7b5   (funct7b5),
        .i_op5        (op[5]),
        .o_alucontrol (ALUControl)
    );

    assign ImmSrc    = imm_src(op);
    assign PCWrite   = ~reset & (w_pcupdate | (w_branch & Zero));
    assign IRWrite   = ~reset & w_irwrite;
    assign RegWrite  = ~reset & w_regwrite;
    assign MemWrite  = ~reset & w_memwrite;
    assign InstrDone = ~reset & w_done;
    assign Illegal   = ~reset & w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed vector bench for multicycle_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    localparam logic [6:0] C_LW  = 7'b0000011;
    localparam logic [6:0] C_SW  = 7'b0100011;
    localparam logic [6:0] C_R   = 7'b0110011;
    localparam logic [6:0] C_I   = 7'b0010011;
    localparam logic [6:0] C_JAL = 7'b1101111;
    localparam logic [6:0] C_BEQ = 7'b1100011;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [17:0] act;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .InstrDone  (InstrDone),
        .Illegal    (Illegal)
    );

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,InstrDone,Illegal}
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUControl, ImmSrc, InstrDone, Illegal};

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        mr;
        logic [17:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [17:0] pk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic [1:0] imm,
                                       input logic done, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, imm, done, ill};
    endfunction

    function automatic logic [17:0] e_rst(input logic [1:0] imm);
        return pk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
    endfunction
    function automatic logic [17:0] e_f(input logic [1:0] imm);
        return pk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
    endfunction
    function automatic logic [17:0] e_d(input logic [1:0] imm, input logic ill);
        return pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, ill);
    endfunction
    function automatic logic [17:0] e_ma(input logic [1:0] imm);
        return pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0, 0);
    endfunction
    function automatic logic [17:0] e_mr(input logic [1:0] imm);
        return pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0, 0);
    endfunction
    function automatic logic [17:0] e_mwb(input logic [1:0] imm);
        return pk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, imm, 1, 0);
    endfunction
    function automatic logic [17:0] e_mw(input logic [1:0] imm);
        return pk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 0);
    endfunction
    function automatic logic [17:0] e_ex(input logic [1:0] sb, input logic [2:0] ac);
        return pk(0, 0, 0, 0, 0, 2'b00, 2'b10, sb, ac, 2'b00, 0, 0);
    endfunction
    function automatic logic [17:0] e_jal();
        return pk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0);
    endfunction
    function automatic logic [17:0] e_wb(input logic [1:0] imm);
        return pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 0);
    endfunction
    function automatic logic [17:0] e_beq(input logic pcw);
        return pk(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1, 0);
    endfunction

    task automatic add(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic mr, input logic [17:0] e);
        vec_t v;
        v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic drv(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic mr);
        reset = rst; op = o; funct3 = f3; funct7b5 = f7; Zero = z; MemReady = mr;
    endtask

    task automatic chk(input string name, input int idx, input logic [17:0] e);
        n_cmp++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s[%0d]: outputs got %b required %b", name, idx, act, e);
        end
    endtask

    // One cycle: drive after the edge, compare mid-cycle, advance to the next edge.
    task automatic cyc(input string name, input int idx, input logic rst, input logic [6:0] o,
                       input logic [2:0] f3, input logic f7, input logic z, input logic mr,
                       input logic [17:0] e);
        drv(rst, o, f3, f7, z, mr);
        @(negedge clk);
        chk(name, idx, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv(1, C_LW, 3'b000, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;

        add(1, C_LW, 3'b000, 0, 0, 1, e_rst(2'b00));
        // lw: 5 cycles
        add(0, C_LW, 3'b010, 0, 0, 1, e_f(2'b00));
        add(0, C_LW, 3'b010, 0, 0, 1, e_d(2'b00, 0));
        add(0, C_LW, 3'b010, 0, 0, 1, e_ma(2'b00));
        add(0, C_LW, 3'b010, 0, 0, 1, e_mr(2'b00));
        add(0, C_LW, 3'b010, 0, 0, 1, e_mwb(2'b00));
        // sw: 4 cycles
        add(0, C_SW, 3'b010, 0, 0, 1, e_f(2'b01));
        add(0, C_SW, 3'b010, 0, 0, 1, e_d(2'b01, 0));
        add(0, C_SW, 3'b010, 0, 0, 1, e_ma(2'b01));
        add(0, C_SW, 3'b010, 0, 0, 1, e_mw(2'b01));
        // R-type sub, and, or, slt, add
        add(0, C_R, 3'b000, 1, 0, 1, e_f(2'b00));
        add(0, C_R, 3'b000, 1, 0, 1, e_d(2'b00, 0));
        add(0, C_R, 3'b000, 1, 0, 1, e_ex(2'b00, 3'b001));
        add(0, C_R, 3'b000, 1, 0, 1, e_wb(2'b00));
        add(0, C_R, 3'b111, 0, 0, 1, e_f(2'b00));
        add(0, C_R, 3'b111, 0, 0, 1, e_d(2'b00, 0));
        add(0, C_R, 3'b111, 0, 0, 1, e_ex(2'b00, 3'b010));
        add(0, C_R, 3'b111, 0, 0, 1, e_wb(2'b00));
        add(0, C_R, 3'b110, 0, 0, 1, e_f(2'b00));
        add(0, C_R, 3'b110, 0, 0, 1, e_d(2'b00, 0));
        add(0, C_R, 3'b110, 0, 0, 1, e_ex(2'b00, 3'b011));
        add(0, C_R, 3'b110, 0, 0, 1, e_wb(2'b00));
        add(0, C_R, 3'b010, 0, 0, 1, e_f(2'b00));
        add(0, C_R, 3'b010, 0, 0, 1, e_d(2'b00, 0));
        add(0, C_R, 3'b010, 0, 0, 1, e_ex(2'b00, 3'b101));
        add(0, C_R, 3'b010, 0, 0, 1, e_wb(2'b00));
        add(0, C_R, 3'b000, 0, 0, 1, e_f(2'b00));
        add(0, C_R, 3'b000, 0, 0, 1, e_d(2'b00, 0));
        add(0, C_R, 3'b000, 0, 0, 1, e_ex(2'b00, 3'b000));
        add(0, C_R, 3'b000, 0, 0, 1, e_wb(2'b00));
        // I-type: funct7b5 set but op[5]=0 stays add; unsupported funct3 -> add
        add(0, C_I, 3'b000, 1, 0, 1, e_f(2'b00));
        add(0, C_I, 3'b000, 1, 0, 1, e_d(2'b00, 0));
        add(0, C_I, 3'b000, 1, 0, 1, e_ex(2'b01, 3'b000));
        add(0, C_I, 3'b000, 1, 0, 1, e_wb(2'b00));
        add(0, C_I, 3'b100, 0, 0, 1, e_f(2'b00));
        add(0, C_I, 3'b100, 0, 0, 1, e_d(2'b00, 0));
        add(0, C_I, 3'b100, 0, 0, 1, e_ex(2'b01, 3'b000));
        add(0, C_I, 3'b100, 0, 0, 1, e_wb(2'b00));
        add(0, C_I, 3'b010, 0, 0, 1, e_f(2'b00));
        add(0, C_I, 3'b010, 0, 0, 1, e_d(2'b00, 0));
        add(0, C_I, 3'b010, 0, 0, 1, e_ex(2'b01, 3'b101));
        add(0, C_I, 3'b010, 0, 0, 1, e_wb(2'b00));
        // jal
        add(0, C_JAL, 3'b000, 0, 0, 1, e_f(2'b11));
        add(0, C_JAL, 3'b000, 0, 0, 1, e_d(2'b11, 0));
        add(0, C_JAL, 3'b000, 0, 0, 1, e_jal());
        add(0, C_JAL, 3'b000, 0, 0, 1, e_wb(2'b11));
        // beq taken / not taken
        add(0, C_BEQ, 3'b000, 0, 1, 1, e_f(2'b10));
        add(0, C_BEQ, 3'b000, 0, 1, 1, e_d(2'b10, 0));
        add(0, C_BEQ, 3'b000, 0, 1, 1, e_beq(1));
        add(0, C_BEQ, 3'b000, 0, 0, 1, e_f(2'b10));
        add(0, C_BEQ, 3'b000, 0, 0, 1, e_d(2'b10, 0));
        add(0, C_BEQ, 3'b000, 0, 0, 1, e_beq(0));
        // illegal opcodes: 2 cycles, no writes
        add(0, 7'b0000000, 3'b000, 0, 0, 1, e_f(2'b00));
        add(0, 7'b0000000, 3'b000, 0, 0, 1, e_d(2'b00, 1));
        add(0, 7'b1111111, 3'b000, 0, 0, 1, e_f(2'b00));
        add(0, 7'b1111111, 3'b000, 0, 0, 1, e_d(2'b00, 1));
        // reset while in MEMREAD abandons the lw, then a full lw runs
        add(0, C_LW, 3'b010, 0, 0, 1, e_f(2'b00));
        add(0, C_LW, 3'b010, 0, 0, 1, e_d(2'b00, 0));
        add(0, C_LW, 3'b010, 0, 0, 1, e_ma(2'b00));
        add(1, C_LW, 3'b010, 0, 0, 1, e_rst(2'b00));
        add(0, C_LW, 3'b010, 0, 0, 1, e_f(2'b00));
        add(0, C_LW, 3'b010, 0, 0, 1, e_d(2'b00, 0));
        add(0, C_LW, 3'b010, 0, 0, 1, e_ma(2'b00));
        add(0, C_LW, 3'b010, 0, 0, 1, e_mr(2'b00));
        add(0, C_LW, 3'b010, 0, 0, 1, e_mwb(2'b00));
        add(0, C_SW, 3'b010, 0, 0, 1, e_f(2'b01));

        for (int i = 0; i < vq.size(); i++) begin
            cyc("vec", i, vq[i].rst, vq[i].op, vq[i].f3, vq[i].f7, vq[i].z, vq[i].mr, vq[i].exp);
        end

`ifdef MC_MEM_WAIT_EN
        // FETCH waits three cycles; MEMWRITE holds MemWrite and delays InstrDone
        cyc("wait", 0, 1, C_SW, 3'b010, 0, 0, 0, e_rst(2'b01));
        for (int i = 1; i <= 3; i++) begin
            cyc("wait", i, 0, C_SW, 3'b010, 0, 0, 0,
                pk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0));
        end
        cyc("wait", 4, 0, C_SW, 3'b010, 0, 0, 1, e_f(2'b01));
        cyc("wait", 5, 0, C_SW, 3'b010, 0, 0, 0, e_d(2'b01, 0));
        cyc("wait", 6, 0, C_SW, 3'b010, 0, 0, 0, e_ma(2'b01));
        cyc("wait", 7, 0, C_SW, 3'b010, 0, 0, 0,
            pk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
        cyc("wait", 8, 0, C_SW, 3'b010, 0, 0, 0,
            pk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
        cyc("wait", 9, 0, C_SW, 3'b010, 0, 0, 1, e_mw(2'b01));
        cyc("wait", 10, 0, C_LW, 3'b010, 0, 0, 0,
            pk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
`else
        // MemReady held low must not stall anything
        cyc("nowait", 0, 1, C_SW, 3'b010, 0, 0, 0, e_rst(2'b01));
        cyc("nowait", 1, 0, C_SW, 3'b010, 0, 0, 0, e_f(2'b01));
        cyc("nowait", 2, 0, C_SW, 3'b010, 0, 0, 0, e_d(2'b01, 0));
        cyc("nowait", 3, 0, C_SW, 3'b010, 0, 0, 0, e_ma(2'b01));
        cyc("nowait", 4, 0, C_SW, 3'b010, 0, 0, 0, e_mw(2'b01));
        cyc("nowait", 5, 0, C_LW, 3'b010, 0, 0, 0, e_f(2'b00));
        cyc("nowait", 6, 0, C_LW, 3'b010, 0, 0, 0, e_d(2'b00, 0));
        cyc("nowait", 7, 0, C_LW, 3'b010, 0, 0, 0, e_ma(2'b00));
        cyc("nowait", 8, 0, C_LW, 3'b010, 0, 0, 0, e_mr(2'b00));
        cyc("nowait", 9, 0, C_LW, 3'b010, 0, 0, 0, e_mwb(2'b00));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
